noc_outport_arbiter: RTL and testbench

//   Per-output-port switch allocator and output register for the 5-port tile NoC router.
//   One instance per router output (N, E, S, W, Local) shares that output among the 5 input ports.
//   - Round-robin arbitration on head flits.
//   - Wormhole lock: the granted input keeps the output until its tail flit is accepted.
//   - One registered flit stage toward the downstream link.

---
 rtl/noc_outport_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_noc_outport_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_outport_arbiter.sv
// noc_outport_arbiter
// Switch allocator plus output register for one router output port.
// Head flits from the inputs compete round-robin. The winner holds the
// output (wormhole lock) until its tail flit is accepted. One registered
// flit stage drives the downstream link.
module noc_outport_arbiter #(
  parameter int NUM_IN   = 5,
  parameter int FLIT_W   = 64,
  parameter int HEAD_BIT = FLIT_W - 1,
  parameter int TAIL_BIT = FLIT_W - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*FLIT_W-1:0] flit_in,
  input  logic [NUM_IN-1:0]        valid_in,
  output logic [NUM_IN-1:0]        ready_out,
  output logic [FLIT_W-1:0]        flit_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [NUM_IN-1:0]        lock_owner,
  output logic                     pkt_done,
  output logic                     err_orphan
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Convert an input index into a one-hot input mask.
  function automatic logic [NUM_IN-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_IN-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [0:0]        state_r;
  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  owner_r;
  logic [NUM_IN-1:0] lock_owner_r;
  logic [FLIT_W-1:0] flit_out_r;
  logic              valid_out_r;
  logic              pkt_done_r;
  logic              err_orphan_r;

  logic              load_ok_s;
  logic [NUM_IN-1:0] eligible_s;
  logic [NUM_IN-1:0] orphan_s;
  logic              grant_vld_s;
  logic [PTR_W-1:0]  grant_idx_s;
  logic [PTR_W-1:0]  scan_idx_s;
  logic [NUM_IN-1:0] ready_s;
  logic              accept_s;
  logic [PTR_W-1:0]  sel_idx_s;
  logic [FLIT_W-1:0] sel_flit_s;
  logic              sel_tail_s;
  logic [PTR_W-1:0]  ptr_next_s;

  // The output stage can take a new flit when it is empty or being drained.
  assign load_ok_s = ~valid_out_r | ready_in;

  // Classify each requesting input: heads may compete, non-heads are orphans when idle.
  always_comb begin
    eligible_s = '0;
    orphan_s   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      eligible_s[i] = valid_in[i] &  flit_in[i*FLIT_W + HEAD_BIT];
      orphan_s[i]   = valid_in[i] & ~flit_in[i*FLIT_W + HEAD_BIT];
    end
  end

  // Round-robin scan from ptr; walking downward lets the closest eligible input win last.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    scan_idx_s  = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      scan_idx_s = PTR_W'((int'(ptr_r) + k) % NUM_IN);
      if (eligible_s[scan_idx_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = scan_idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Per-input ready: the winning head in IDLE or the lock owner, gated by output space and reset.
  always_comb begin
    ready_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) begin
          ready_s = onehot(grant_idx_s);
        end else begin
          ready_s = '0;
        end
      end
      ST_LOCKED: ready_s = lock_owner_r;
      default:   ready_s = '0;
    endcase
    ready_s = ready_s & {NUM_IN{load_ok_s & ~rst}};
  end

  assign accept_s = |(ready_s & valid_in);

  // Select which input's flit is forwarded: the owner while locked, else the arbitration winner.
  always_comb begin
    sel_flit_s = '0;
    if (state_r == ST_LOCKED) begin
      sel_idx_s = owner_r;
    end else begin
      sel_idx_s = grant_idx_s;
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_idx_s == PTR_W'(i)) begin
        sel_flit_s = flit_in[i*FLIT_W +: FLIT_W];
      end else begin
        sel_flit_s = sel_flit_s;
      end
    end
  end

  assign sel_tail_s = sel_flit_s[TAIL_BIT];

  // Priority moves one past the input that actually won, wrapping at NUM_IN-1.
  always_comb begin
    if (grant_idx_s == PTR_W'(NUM_IN - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + 1'b1;
    end
  end

  // Arbitration state, wormhole lock, output register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      owner_r      <= '0;
      lock_owner_r <= '0;
      flit_out_r   <= '0;
      valid_out_r  <= 1'b0;
      pkt_done_r   <= 1'b0;
      err_orphan_r <= 1'b0;
    end else begin
      pkt_done_r <= 1'b0;

      if (load_ok_s) begin
        if (accept_s) begin
          flit_out_r  <= sel_flit_s;
          valid_out_r <= 1'b1;
        end else begin
          valid_out_r <= 1'b0;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (|orphan_s) begin
            err_orphan_r <= 1'b1;
          end
          if (accept_s) begin
            ptr_r <= ptr_next_s;
            if (sel_tail_s) begin
              pkt_done_r <= 1'b1;
            end else begin
              state_r      <= ST_LOCKED;
              owner_r      <= grant_idx_s;
              lock_owner_r <= onehot(grant_idx_s);
            end
          end
        end
        ST_LOCKED: begin
          if (accept_s && sel_tail_s) begin
            state_r      <= ST_IDLE;
            lock_owner_r <= '0;
            pkt_done_r   <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          lock_owner_r <= '0;
        end
      endcase
    end
  end

  assign ready_out  = ready_s;
  assign flit_out   = flit_out_r;
  assign valid_out  = valid_out_r;
  assign lock_owner = lock_owner_r;
  assign pkt_done   = pkt_done_r;
  assign err_orphan = err_orphan_r;

endmodule

// File: tb/tb_noc_outport_arbiter.sv
// tb_noc_outport_arbiter
// Directed scenarios plus a randomized run against a behavioural model of the
// round-robin / wormhole rules for noc_outport_arbiter.
module tb_noc_outport_arbiter;

  localparam int N  = 5;
  localparam int W  = 64;
  localparam int HB = W - 1;
  localparam int TB = W - 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] flit_in;
  logic [N-1:0]   valid_in;
  logic [N-1:0]   ready_out;
  logic [W-1:0]   flit_out;
  logic           valid_out;
  logic           ready_in;
  logic [N-1:0]   lock_owner;
  logic           pkt_done;
  logic           err_orphan;

  int checks = 0;
  int errors = 0;

  noc_outport_arbiter #(.NUM_IN(N), .FLIT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flit_in    (flit_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .flit_out   (flit_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .lock_owner (lock_owner),
    .pkt_done   (pkt_done),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mkf(input logic h, input logic t, input logic [7:0] src, input logic [7:0] seq);
    logic [W-1:0] f;
    f = {$urandom, $urandom};
    f[HB] = h;
    f[TB] = t;
    f[7:0] = src;
    f[15:8] = seq;
    return f;
  endfunction

  task automatic put(input int i, input logic [W-1:0] f, input logic v);
    flit_in[i*W +: W] = f;
    valid_in[i] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_in = '0;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready_in = 1'b1;
    for (int i = 0; i < N; i++) put(i, mkf(1'b1, 1'b0, 8'(i), 8'd0), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready_out !== 5'b00000) begin errors++; $display("FAIL reset_ready: got %b expected %b", ready_out, 5'b00000); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    checks++; if (lock_owner !== 5'b00000) begin errors++; $display("FAIL reset_lock_owner: got %b expected 00000", lock_owner); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %b expected 0", err_orphan); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done: got %b expected 0", pkt_done); end
    checks++; if (flit_out !== 64'd0) begin errors++; $display("FAIL reset_flit_out: got %h expected 0", flit_out); end
    valid_in = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rr_fairness();
    int ord [6] = '{0, 2, 4, 0, 2, 4};
    logic [W-1:0] f [N];
    logic [N-1:0] e;
    do_reset();
    for (int i = 0; i < N; i++) f[i] = mkf(1'b1, 1'b1, 8'(i), 8'd0);
    put(0, f[0], 1'b1);
    put(2, f[2], 1'b1);
    put(4, f[4], 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1;
      e = 5'b00001 << ord[c];
      checks++; if (ready_out !== e) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, ready_out, e); end
      @(posedge clk);
      #1;
      checks++; if (flit_out !== f[ord[c]] || valid_out !== 1'b1) begin errors++; $display("FAIL rr_flit[%0d]: got %h/%b expected %h/1", c, flit_out, valid_out, f[ord[c]]); end
      checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL rr_pkt_done[%0d]: got %b expected 1", c, pkt_done); end
    end
    valid_in = '0;
    @(posedge clk);
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", valid_out); end
  endtask

  task automatic test_wormhole();
    logic [W-1:0] pk [4];
    logic [W-1:0] h3;
    do_reset();
    pk[0] = mkf(1'b1, 1'b0, 8'd1, 8'd0);
    pk[1] = mkf(1'b0, 1'b0, 8'd1, 8'd1);
    pk[2] = mkf(1'b0, 1'b0, 8'd1, 8'd2);
    pk[3] = mkf(1'b0, 1'b1, 8'd1, 8'd3);
    h3 = mkf(1'b1, 1'b1, 8'd3, 8'd0);
    put(3, h3, 1'b1);
    for (int c = 0; c < 4; c++) begin
      put(1, pk[c], 1'b1);
      #1;
      checks++; if (ready_out !== 5'b00010) begin errors++; $display("FAIL worm_ready[%0d]: got %b expected 00010", c, ready_out); end
      @(posedge clk);
      #1;
      checks++; if (flit_out !== pk[c]) begin errors++; $display("FAIL worm_flit[%0d]: got %h expected %h", c, flit_out, pk[c]); end
      checks++; if (lock_owner !== ((c < 3) ? 5'b00010 : 5'b00000)) begin errors++; $display("FAIL worm_lock[%0d]: got %b", c, lock_owner); end
      checks++; if (pkt_done !== (c == 3)) begin errors++; $display("FAIL worm_done[%0d]: got %b expected %b", c, pkt_done, (c == 3)); end
    end
    put(1, '0, 1'b0);
    #1;
    checks++; if (ready_out !== 5'b01000) begin errors++; $display("FAIL worm_next_ready: got %b expected 01000", ready_out); end
    @(posedge clk);
    #1;
    checks++; if (flit_out !== h3 || pkt_done !== 1'b1 || lock_owner !== 5'b00000) begin errors++; $display("FAIL worm_next_flit: got %h/%b/%b expected %h/1/00000", flit_out, pkt_done, lock_owner, h3); end
    valid_in = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pk [4];
    do_reset();
    for (int c = 0; c < 4; c++) pk[c] = mkf(c == 0, c == 3, 8'd0, 8'(c));
    for (int c = 0; c < 2; c++) begin
      put(0, pk[c], 1'b1);
      @(posedge clk);
      #1;
      checks++; if (flit_out !== pk[c] || lock_owner !== 5'b00001) begin errors++; $display("FAIL bp_pre[%0d]: got %h/%b expected %h/00001", c, flit_out, lock_owner, pk[c]); end
    end
    ready_in = 1'b0;
    put(0, pk[2], 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (ready_out !== 5'b00000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 00000", c, ready_out); end
      @(posedge clk);
      #1;
      checks++; if (flit_out !== pk[1] || valid_out !== 1'b1 || lock_owner !== 5'b00001) begin errors++; $display("FAIL bp_hold[%0d]: got %h/%b/%b expected %h/1/00001", c, flit_out, valid_out, lock_owner, pk[1]); end
    end
    ready_in = 1'b1;
    #1;
    checks++; if (ready_out !== 5'b00001) begin errors++; $display("FAIL bp_resume_ready: got %b expected 00001", ready_out); end
    @(posedge clk);
    #1;
    checks++; if (flit_out !== pk[2]) begin errors++; $display("FAIL bp_resume_flit: got %h expected %h", flit_out, pk[2]); end
    put(0, pk[3], 1'b1);
    @(posedge clk);
    #1;
    checks++; if (flit_out !== pk[3] || pkt_done !== 1'b1 || lock_owner !== 5'b00000) begin errors++; $display("FAIL bp_tail: got %h/%b/%b expected %h/1/00000", flit_out, pkt_done, lock_owner, pk[3]); end
    valid_in = '0;
    @(posedge clk);
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", valid_out); end
  endtask

  task automatic test_orphan();
    logic [W-1:0] hf;
    do_reset();
    put(2, mkf(1'b0, 1'b0, 8'd2, 8'd0), 1'b1);
    #1;
    checks++; if (ready_out !== 5'b00000) begin errors++; $display("FAIL orphan_ready: got %b expected 00000", ready_out); end
    @(posedge clk);
    #1;
    checks++; if (err_orphan !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL orphan_flag: got %b/%b expected 1/0", err_orphan, valid_out); end
    put(2, '0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan); end
    end
    hf = mkf(1'b1, 1'b1, 8'd2, 8'd1);
    put(2, hf, 1'b1);
    #1;
    checks++; if (ready_out !== 5'b00100) begin errors++; $display("FAIL orphan_head_ready: got %b expected 00100", ready_out); end
    @(posedge clk);
    #1;
    checks++; if (flit_out !== hf || err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_head_flit: got %h/%b expected %h/1", flit_out, err_orphan, hf); end
    valid_in = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_packet();
    logic [W-1:0] pk [4];
    logic [W-1:0] hf;
    do_reset();
    for (int c = 0; c < 4; c++) pk[c] = mkf(c == 0, c == 3, 8'd4, 8'(c));
    for (int c = 0; c < 2; c++) begin
      put(4, pk[c], 1'b1);
      @(posedge clk);
      #1;
    end
    checks++; if (flit_out !== pk[1] || lock_owner !== 5'b10000) begin errors++; $display("FAIL rmid_pre: got %h/%b expected %h/10000", flit_out, lock_owner, pk[1]); end
    rst = 1'b1;
    put(4, pk[2], 1'b1);
    #1;
    checks++; if (ready_out !== 5'b00000) begin errors++; $display("FAIL rmid_ready: got %b expected 00000", ready_out); end
    @(posedge clk);
    #1;
    checks++; if (valid_out !== 1'b0 || lock_owner !== 5'b00000 || pkt_done !== 1'b0 || flit_out !== 64'd0) begin errors++; $display("FAIL rmid_state: got %b/%b/%b/%h expected 0/00000/0/0", valid_out, lock_owner, pkt_done, flit_out); end
    rst = 1'b0;
    hf = mkf(1'b1, 1'b1, 8'd4, 8'd9);
    put(4, hf, 1'b1);
    #1;
    checks++; if (ready_out !== 5'b10000) begin errors++; $display("FAIL rmid_new_ready: got %b expected 10000", ready_out); end
    @(posedge clk);
    #1;
    checks++; if (flit_out !== hf || pkt_done !== 1'b1 || lock_owner !== 5'b00000) begin errors++; $display("FAIL rmid_new_flit: got %h/%b/%b expected %h/1/00000", flit_out, pkt_done, lock_owner, hf); end
    valid_in = '0;
    @(posedge clk);
    #1;
  endtask

  // Randomized traffic against a model of the arbitration rules.
  task automatic test_random();
    bit           m_locked = 1'b0;
    int           m_owner  = 0;
    int           m_ptr    = 0;
    bit           m_vout   = 1'b0;
    logic [W-1:0] m_fout   = '0;
    bit           m_err    = 1'b0;
    bit           m_done   = 1'b0;
    bit           load_ok;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_lock;
    logic [W-1:0] sel;
    int           g;
    int           acc;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++)
        put(i, mkf($urandom_range(0, 19) != 0, $urandom_range(0, 1) == 1, 8'(i), 8'(cyc)),
            $urandom_range(0, 1) == 1);
      ready_in = ($urandom_range(0, 3) != 0);
      #1;
      load_ok = !m_vout || ready_in;
      exp_ready = '0;
      g = -1;
      if (m_locked) begin
        if (load_ok) exp_ready[m_owner] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (g < 0 && valid_in[j] && flit_in[j*W + HB]) g = j;
        end
        if (g >= 0 && load_ok) exp_ready[g] = 1'b1;
      end
      checks++; if (ready_out !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, ready_out, exp_ready); end
      acc = -1;
      for (int i = 0; i < N; i++) if (exp_ready[i] && valid_in[i]) acc = i;
      sel = (acc >= 0) ? flit_in[acc*W +: W] : '0;
      m_done = 1'b0;
      if (!m_locked) begin
        for (int i = 0; i < N; i++) if (valid_in[i] && !flit_in[i*W + HB]) m_err = 1'b1;
        if (acc >= 0) begin
          m_ptr = (acc + 1) % N;
          if (sel[TB]) m_done = 1'b1;
          else begin m_locked = 1'b1; m_owner = acc; end
        end
      end else if (acc >= 0 && sel[TB]) begin
        m_locked = 1'b0;
        m_done = 1'b1;
      end
      if (load_ok) begin
        if (acc >= 0) begin m_vout = 1'b1; m_fout = sel; end
        else m_vout = 1'b0;
      end
      exp_lock = m_locked ? (5'b00001 << m_owner) : 5'b00000;
      @(posedge clk);
      #1;
      checks++; if (valid_out !== m_vout || flit_out !== m_fout) begin errors++; $display("FAIL rand_out[%0d]: got %b/%h expected %b/%h", cyc, valid_out, flit_out, m_vout, m_fout); end
      checks++; if (lock_owner !== exp_lock) begin errors++; $display("FAIL rand_lock[%0d]: got %b expected %b", cyc, lock_owner, exp_lock); end
      checks++; if (pkt_done !== m_done || err_orphan !== m_err) begin errors++; $display("FAIL rand_flags[%0d]: got %b/%b expected %b/%b", cyc, pkt_done, err_orphan, m_done, m_err); end
      if (errors > 30) break;
    end
    valid_in = '0;
  endtask

  initial begin
    rst = 1'b1;
    flit_in = '0;
    valid_in = '0;
    ready_in = 1'b1;
    #1;
    test_reset();
    test_rr_fairness();
    test_wormhole();
    test_backpressure();
    test_orphan();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
